// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and state encoding for the mux select arbiter
package mux_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin pick: first set request after ptr, wrapping mod N_CH
module rr_pick
  import mux_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest candidate back to ptr+1 so the nearest requester after ptr wins.
  // The SEL_W-bit add wraps naturally, which is the rotate / rotate-back.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = N_CH; k >= 1; k--) begin
      cand = ptr + k[SEL_W-1:0];
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - round-robin arbiter driving the 4:1 mux select with a dwell hold
module mux_sel_arbiter
  import mux_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  req,
  output logic [SEL_W-1:0] sel,
  output logic [N_CH-1:0]  gnt,
  output logic             gnt_valid,
  input  logic             gnt_ready,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);
  localparam logic [N_CH-1:0]  ONE_HOT0 = {{(N_CH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Grant FSM: offer in GRANT, hold sel for the dwell window in HOLD, all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= SEL_W'(N_CH - 1);
      cnt       <= '0;
      sel       <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          gnt <= '0;
          if (pick_found) begin
            sel       <= pick_idx;
            gnt       <= ONE_HOT0 << pick_idx;
            gnt_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Acceptance wins over a same-cycle withdrawal.
          if (gnt_ready) begin
            gnt_valid <= 1'b0;
            cnt       <= CNT_LOAD;
            ptr       <= sel;
            state     <= ST_HOLD;
          end else if (!req[sel]) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (cnt == '0) begin
            gnt   <= '0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          gnt       <= '0;
          gnt_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb/tb_mux_sel_arbiter.sv - self-checking bench for mux_sel_arbiter with a mux4 on sel
module tb_mux_sel_arbiter;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       gnt_ready = 1'b0;
  logic       busy;

  logic [7:0] din [4];
  logic [7:0] y;

  int errors = 0;
  int checks = 0;

  mux_sel_arbiter #(.DWELL(DWELL), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .sel       (sel),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_ready (gnt_ready),
    .busy      (busy)
  );

  // 4:1 mux stage fed from sel
  assign y = din[sel];

  always #5 clk = ~clk;

  // Behavioural model: phase 0 = no grant, 1 = offered, 2 = dwelling for m_left more edges
  int m_phase = 0;
  int m_ptr   = 3;
  int m_sel   = 0;
  int m_left  = 0;
  bit m_live  = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0;
      m_ptr   = 3;
      m_sel   = 0;
      m_left  = 0;
      m_live  = 1'b1;
    end else if (m_phase == 0) begin
      for (int k = 1; k <= 4; k++) begin
        if (m_phase == 0 && req[(m_ptr + k) % 4]) begin
          m_sel   = (m_ptr + k) % 4;
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (gnt_ready) begin
        m_ptr   = m_sel;
        m_left  = DWELL;
        m_phase = 2;
      end else if (!req[m_sel]) begin
        m_phase = 0;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) m_phase = 0;
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(posedge clk) begin
    #1;
    if (m_live) begin
      logic [3:0] e_gnt;
      e_gnt = (m_phase != 0) ? (4'b0001 << m_sel) : 4'b0000;
      checks++;
      if (sel !== 2'(m_sel) || gnt !== e_gnt || gnt_valid !== (m_phase == 1) ||
          busy !== (m_phase != 0) || y !== din[m_sel]) begin
        errors++;
        $display("FAIL model t=%0t got sel=%0d gnt=%b v=%b busy=%b y=%h want sel=%0d gnt=%b v=%0d busy=%0d y=%h",
                 $time, sel, gnt, gnt_valid, busy, y, m_sel, e_gnt, (m_phase == 1), (m_phase != 0), din[m_sel]);
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic expect_lit(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Wait (bounded) for an offered grant, then check its channel
  task automatic wait_grant(input string name, input int want_ch);
    int n;
    n = 0;
    while (gnt_valid !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout got gnt_valid=%b want 1", name, gnt_valid);
    end else if (sel !== 2'(want_ch)) begin
      errors++;
      $display("FAIL %s got sel=%0d want %0d", name, sel, want_ch);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    din[0] = 8'hA0; din[1] = 8'hB1; din[2] = 8'hC2; din[3] = 8'hD3;

    // 1 reset with all requests high
    req = 4'b1111;
    step(2);
    expect_lit("reset_sel", {6'd0, sel}, 8'd0);
    expect_lit("reset_gnt", {4'd0, gnt}, 8'd0);
    expect_lit("reset_valid", {7'd0, gnt_valid}, 8'd0);
    expect_lit("reset_busy", {7'd0, busy}, 8'd0);

    // 2 round robin 0,1,2,3,0
    gnt_ready = 1'b1;
    rst_n = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_grant($sformatf("rr_%0d", g), g % 4);
      step(1);
    end
    step(1);
    expect_lit("rr_hold_sel", {6'd0, sel}, 8'd0);
    expect_lit("rr_hold_busy", {7'd0, busy}, 8'd1);

    // 3 withdraw after two unaccepted cycles
    gnt_ready = 1'b0;
    req = 4'b0000;
    step(6);
    do_reset();
    req = 4'b0100;
    wait_grant("wd_first", 2);
    step(2);
    req = 4'b0000;
    step(1);
    expect_lit("wd_valid", {7'd0, gnt_valid}, 8'd0);
    expect_lit("wd_busy", {7'd0, busy}, 8'd0);
    expect_lit("wd_gnt", {4'd0, gnt}, 8'd0);
    req = 4'b0100;
    wait_grant("wd_regrant", 2);

    // 4 ready and withdraw in the same cycle
    req = 4'b0000;
    gnt_ready = 1'b1;
    step(1);
    gnt_ready = 1'b0;
    expect_lit("rw_busy", {7'd0, busy}, 8'd1);
    expect_lit("rw_gnt", {4'd0, gnt}, 8'b0000_0100);
    expect_lit("rw_valid", {7'd0, gnt_valid}, 8'd0);
    step(3);
    expect_lit("rw_sel_end", {6'd0, sel}, 8'd2);
    step(1);
    expect_lit("rw_idle", {7'd0, busy}, 8'd0);

    // 5 wrap from ptr=2, late request for channel 3 arrives mid-hold
    req = 4'b0011;
    gnt_ready = 1'b1;
    wait_grant("wrap_0", 0);
    step(2);
    req = 4'b1011;
    wait_grant("wrap_1", 1);
    step(1);
    req = 4'b1000;
    wait_grant("wrap_3", 3);
    step(1);
    req = 4'b0000;
    step(6);

    // 6 reset mid-hold, then restart from channel 0
    req = 4'b1111;
    wait_grant("rst_pre", 0);
    step(3);
    rst_n = 1'b0;
    step(1);
    expect_lit("rst_mid_gnt", {4'd0, gnt}, 8'd0);
    expect_lit("rst_mid_sel", {6'd0, sel}, 8'd0);
    expect_lit("rst_mid_busy", {7'd0, busy}, 8'd0);
    rst_n = 1'b1;
    wait_grant("rst_restart", 0);
    step(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
